// File: rtl/lmk_init_sequencer.sv
// Register-table walker feeding the LMK I2C write block, with inter-write gap and done/error status.
// Optional watchdog: define LMK_INIT_TIMEOUT_EN.
module lmk_init_sequencer #(
    parameter int unsigned NUM_REGS       = 16,
    parameter int unsigned IDX_W          = 5,
    parameter int unsigned GAP_CYCLES     = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             go,
    output logic [IDX_W-1:0] entry_idx,
    input  logic [6:0]       entry_addr,
    input  logic [15:0]      entry_data,
    input  logic             entry_last,
    output logic             i2c_start_write,
    output logic [6:0]       i2c_address,
    output logic [15:0]      i2c_data,
    input  logic             i2c_ready_n,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [IDX_W-1:0] writes_done
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StIssue,
        StWaitAccept,
        StWaitDone,
        StGap,
        StFinish
    } state_e;

    localparam int unsigned GAP_W      = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int unsigned GAP_LAST_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    state_e               r_state;
    state_e               w_state_next;
    logic [IDX_W-1:0]     r_idx;
    logic [IDX_W-1:0]     r_writes;
    logic [6:0]           r_addr;
    logic [15:0]          r_data;
    logic                 r_last;
    logic                 r_start_write;
    logic                 r_busy;
    logic                 r_done;
    logic [GAP_W-1:0]     r_gap_cnt;

    logic                 w_go_accept;
    logic                 w_issue;
    logic                 w_write_done;
    logic                 w_timeout;

`ifdef LMK_INIT_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] r_wdog_cnt;
    logic            r_error;
    logic            w_wdog_state;

    assign w_wdog_state = (r_state == StIssue) || (r_state == StWaitAccept) ||
                          (r_state == StWaitDone);
`endif

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_go_accept  = 1'b0;
        w_issue      = 1'b0;
        w_write_done = 1'b0;
        w_timeout    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (go) begin
                    w_go_accept  = 1'b1;
                    w_state_next = StFetch;
                end
            end
            StFetch: w_state_next = StIssue;
            StIssue: begin
                if (!i2c_ready_n) begin
                    w_issue      = 1'b1;
                    w_state_next = StWaitAccept;
                end
            end
            StWaitAccept: begin
                if (i2c_ready_n) begin
                    w_state_next = StWaitDone;
                end
            end
            StWaitDone: begin
                if (!i2c_ready_n) begin
                    w_write_done = 1'b1;
                    if (r_last) begin
                        w_state_next = StFinish;
                    end else if (GAP_CYCLES == 0) begin
                        w_state_next = StFetch;
                    end else begin
                        w_state_next = StGap;
                    end
                end
            end
            StGap: begin
                if (r_gap_cnt == GAP_W'(GAP_LAST_I)) begin
                    w_state_next = StFetch;
                end
            end
            StFinish: w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
`ifdef LMK_INIT_TIMEOUT_EN
        // Fires after TIMEOUT_CYCLES consecutive cycles stuck in one handshake state.
        if (w_wdog_state && (w_state_next == r_state) &&
            (r_wdog_cnt == TO_W'(TIMEOUT_CYCLES - 1))) begin
            w_timeout    = 1'b1;
            w_state_next = StIdle;
        end
`endif
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_idx         <= '0;
            r_writes      <= '0;
            r_addr        <= '0;
            r_data        <= '0;
            r_last        <= 1'b0;
            r_start_write <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_gap_cnt     <= '0;
        end else begin
            r_start_write <= w_issue;
            if (w_go_accept) begin
                r_idx    <= '0;
                r_writes <= '0;
                r_done   <= 1'b0;
                r_busy   <= 1'b1;
            end
            if (r_state == StFetch) begin
                r_addr <= entry_addr;
                r_data <= entry_data;
                r_last <= entry_last || (r_idx == IDX_W'(NUM_REGS - 1));
            end
            if (w_write_done) begin
                r_writes <= r_writes + IDX_W'(1);
                if (!r_last) begin
                    r_idx <= r_idx + IDX_W'(1);
                end
            end
            if (r_state == StFinish) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
            if (w_timeout) begin
                r_busy <= 1'b0;
            end
            if (r_state == StGap) begin
                r_gap_cnt <= r_gap_cnt + GAP_W'(1);
            end else begin
                r_gap_cnt <= '0;
            end
        end
    end

`ifdef LMK_INIT_TIMEOUT_EN
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_wdog_cnt <= '0;
            r_error    <= 1'b0;
        end else begin
            if (w_wdog_state && (w_state_next == r_state)) begin
                r_wdog_cnt <= r_wdog_cnt + TO_W'(1);
            end else begin
                r_wdog_cnt <= '0;
            end
            if (w_go_accept) begin
                r_error <= 1'b0;
            end else if (w_timeout) begin
                r_error <= 1'b1;
            end
        end
    end

    assign error = r_error;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign error            = 1'b0;
`endif

    assign entry_idx       = r_idx;
    assign writes_done     = r_writes;
    assign i2c_address     = r_addr;
    assign i2c_data        = r_data;
    assign i2c_start_write = r_start_write;
    assign busy            = r_busy;
    assign done            = r_done;

endmodule

// File: tb/tb_lmk_init_sequencer.sv
// Directed, table-driven bench for lmk_init_sequencer with a simple I2C busy-flag model.
// Timeout checks are compiled in when LMK_INIT_TIMEOUT_EN is defined.
module tb_lmk_init_sequencer;

    localparam int unsigned NUM_REGS = 16;
    localparam int unsigned IDX_W    = 5;

    logic             clk = 1'b0;
    logic             nReset = 1'b0;
    logic             go = 1'b0;
    logic [IDX_W-1:0] entry_idx;
    logic [6:0]       entry_addr;
    logic [15:0]      entry_data;
    logic             entry_last;
    logic             i2c_start_write;
    logic [6:0]       i2c_address;
    logic [15:0]      i2c_data;
    logic             i2c_ready_n;
    logic             busy;
    logic             done;
    logic             error;
    logic [IDX_W-1:0] writes_done;

    logic [6:0]  tbl_addr [32];
    logic [15:0] tbl_data [32];
    int          last_idx = 2;

    // I2C model state
    logic        model_en  = 1'b1;
    logic        model_rdy = 1'b0;
    logic        force_rdy = 1'b0;
    int          xfer_len  = 50;
    int          busy_cnt  = 0;
    int          n_starts  = 0;
    logic [22:0] cap [128];

    int n_cmp = 0;
    int n_bad = 0;
    int base;
    int waited;

    typedef struct {
        int last_idx;
        int xfer;
        int exp_writes;
        int exp_idx;
    } vec_t;

    vec_t vecs [4];

    lmk_init_sequencer #(
        .NUM_REGS      (NUM_REGS),
        .IDX_W         (IDX_W),
        .GAP_CYCLES    (4),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk            (clk),
        .nReset         (nReset),
        .go             (go),
        .entry_idx      (entry_idx),
        .entry_addr     (entry_addr),
        .entry_data     (entry_data),
        .entry_last     (entry_last),
        .i2c_start_write(i2c_start_write),
        .i2c_address    (i2c_address),
        .i2c_data       (i2c_data),
        .i2c_ready_n    (i2c_ready_n),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .writes_done    (writes_done)
    );

    always #5 clk = ~clk;

    assign entry_addr  = tbl_addr[entry_idx];
    assign entry_data  = tbl_data[entry_idx];
    assign entry_last  = (int'(entry_idx) == last_idx);
    assign i2c_ready_n = model_en ? model_rdy : force_rdy;

    always @(negedge clk) begin
        if (!nReset) begin
            model_rdy = 1'b0;
            busy_cnt  = 0;
        end else begin
            if (busy_cnt > 0) begin
                busy_cnt = busy_cnt - 1;
                if (busy_cnt == 0) model_rdy = 1'b0;
            end
            if (i2c_start_write) begin
                if (n_starts < 128) cap[n_starts] = {i2c_address, i2c_data};
                n_starts  = n_starts + 1;
                model_rdy = 1'b1;
                busy_cnt  = xfer_len;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_go;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_finish(input string name);
        int n = 0;
        while (!(done || error) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_finished"}, 32'(done || error), 32'd1);
    endtask

    task automatic chk_writes(input string name, input int first, input int count);
        for (int k = 0; k < count; k++) begin
            chk($sformatf("%s_write%0d", name, k), 32'(cap[(first + k) % 128]),
                32'({tbl_addr[k], tbl_data[k]}));
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            tbl_addr[i] = 7'((i * 13 + 5) & 7'h7f);
            tbl_data[i] = 16'hA500 ^ 16'(i * 16'h1111);
        end
        vecs[0] = '{2, 50, 3, 2};
        vecs[1] = '{255, 3, 16, 15};
        vecs[2] = '{0, 1, 1, 0};
        vecs[3] = '{5, 7, 6, 5};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_idx", 32'(entry_idx), 0);
        chk("rst_start", 32'(i2c_start_write), 0);
        chk("rst_addr_data", 32'({i2c_address, i2c_data}), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_writes", 32'(writes_done), 0);
        nReset = 1'b1;
        @(negedge clk);

        // Start latency: FETCH, ISSUE, then the start pulse
        last_idx = 0;
        xfer_len = 3;
        base     = n_starts;
        pulse_go();
        chk("lat_e1_start", 32'(i2c_start_write), 0);
        chk("lat_e1_busy", 32'(busy), 1);
        @(negedge clk);
        chk("lat_e2_start", 32'(i2c_start_write), 0);
        chk("lat_e2_addr_data", 32'({i2c_address, i2c_data}), 32'({tbl_addr[0], tbl_data[0]}));
        @(negedge clk);
        chk("lat_e3_start", 32'(i2c_start_write), 1);
        wait_finish("lat");
        chk("lat_nstarts", 32'(n_starts - base), 1);

        // Table-driven runs
        for (int v = 0; v < 4; v++) begin
            last_idx = vecs[v].last_idx;
            xfer_len = vecs[v].xfer;
            base     = n_starts;
            pulse_go();
            chk($sformatf("v%0d_done_cleared", v), 32'(done), 0);
            wait_finish($sformatf("v%0d", v));
            @(negedge clk);
            chk($sformatf("v%0d_writes", v), 32'(writes_done), 32'(vecs[v].exp_writes));
            chk($sformatf("v%0d_idx", v), 32'(entry_idx), 32'(vecs[v].exp_idx));
            chk($sformatf("v%0d_done", v), 32'(done), 1);
            chk($sformatf("v%0d_busy", v), 32'(busy), 0);
            chk($sformatf("v%0d_error", v), 32'(error), 0);
            chk($sformatf("v%0d_nstarts", v), 32'(n_starts - base), 32'(vecs[v].exp_writes));
            chk_writes($sformatf("v%0d", v), base, vecs[v].exp_writes);
        end

        // ready_n held high at go: no request until it falls
        last_idx  = 0;
        xfer_len  = 4;
        model_en  = 1'b0;
        force_rdy = 1'b1;
        base      = n_starts;
        pulse_go();
        repeat (20) @(negedge clk);
        chk("hold_no_start", 32'(n_starts - base), 0);
        chk("hold_busy", 32'(busy), 1);
        force_rdy = 1'b0;
        model_en  = 1'b1;
        wait_finish("hold");
        chk("hold_one_start", 32'(n_starts - base), 1);
        chk("hold_done", 32'(done), 1);

        // go during WAIT_DONE and GAP is ignored
        last_idx = 2;
        xfer_len = 50;
        base     = n_starts;
        pulse_go();
        waited = 0;
        while (n_starts == base && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        repeat (5) @(negedge clk);
        pulse_go();
        waited = 0;
        while (i2c_ready_n && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        @(negedge clk);
        pulse_go();
        wait_finish("ign");
        @(negedge clk);
        chk("ign_nstarts", 32'(n_starts - base), 3);
        chk("ign_writes", 32'(writes_done), 3);
        chk("ign_done", 32'(done), 1);
        chk_writes("ign", base, 3);

        // Asynchronous reset during WAIT_ACCEPT
        xfer_len = 5;
        pulse_go();
        waited = 0;
        while (!i2c_start_write && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        chk("ar_saw_start", 32'(i2c_start_write), 1);
        #1 nReset = 1'b0;
        #1;
        chk("ar_start", 32'(i2c_start_write), 0);
        chk("ar_busy", 32'(busy), 0);
        chk("ar_idx", 32'(entry_idx), 0);
        chk("ar_addr_data", 32'({i2c_address, i2c_data}), 0);
        chk("ar_writes", 32'(writes_done), 0);
        repeat (2) @(negedge clk);
        nReset = 1'b1;
        @(negedge clk);
        base = n_starts;
        pulse_go();
        wait_finish("ar_rerun");
        @(negedge clk);
        chk("ar_rerun_writes", 32'(writes_done), 3);
        chk("ar_rerun_nstarts", 32'(n_starts - base), 3);
        chk_writes("ar_rerun", base, 3);

`ifdef LMK_INIT_TIMEOUT_EN
        // ready_n stuck high during write 2
        last_idx = 2;
        xfer_len = 5;
        base     = n_starts;
        pulse_go();
        waited = 0;
        while (n_starts < base + 2 && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        model_en  = 1'b0;
        force_rdy = 1'b1;
        repeat (80) @(negedge clk);
        chk("to_no_error_yet", 32'(error), 0);
        waited = 0;
        while (!error && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        chk("to_error", 32'(error), 1);
        chk("to_writes", 32'(writes_done), 1);
        chk("to_done", 32'(done), 0);
        chk("to_busy", 32'(busy), 0);
        force_rdy = 1'b0;
        model_en  = 1'b1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lmk_init_sequencer.md
# lmk_init_sequencer

Upstream stage of the LMK I2C writer. It walks a register table, presents each 7-bit-address/16-bit-data entry to the I2C write block, and handshakes on that block's `ready_n`. Successive writes are separated by a programmable gap, and it reports done or error for the whole sequence. It sits between the ADC-fast bring-up control logic and the I2C top level; the table itself is an external combinational lookup indexed by this block.

## Interface
- `NUM_REGS`, 16: maximum table entries; the sequence ends at the entry with `entry_last` set or at index `NUM_REGS-1`.
- `IDX_W`, 5: width of the entry index and the write counter; must satisfy 2^IDX_W > NUM_REGS.
- `GAP_CYCLES`, 1000: idle clk cycles between the end of one write and the next issue (10 µs at 100 MHz); 0 means no gap.
- `TIMEOUT_CYCLES`, 200000: watchdog limit per handshake phase; used only with `LMK_INIT_TIMEOUT_EN`.

Ports (clock and reset first):
- `clk`  in  1  system clock, 100 MHz, same clock as the I2C block.
- `nReset`  in  1  asynchronous, active-low reset.
- `go`  in  1  single-cycle start request.
- `entry_idx`  out  IDX_W  table index being fetched.
- `entry_addr`  in  7  table lookup: I2C slave address.
- `entry_data`  in  16  table lookup: register word, sent high byte first downstream.
- `entry_last`  in  1  table lookup: this entry is the final one.
- `i2c_start_write`  out  1  one-cycle write request to the I2C block.
- `i2c_address`  out  7  registered address, stable from FETCH through WAIT_DONE.
- `i2c_data`  out  16  registered data, stable from FETCH through WAIT_DONE.
- `i2c_ready_n`  in  1  I2C block busy flag: high while a transfer runs, low when idle.
- `busy`  out  1  sequence in progress.
- `done`  out  1  sticky: sequence completed without error.
- `error`  out  1  sticky: watchdog fired.
- `writes_done`  out  IDX_W  count of completed writes in the current or last run.

## Operation
- States: IDLE, FETCH, ISSUE, WAIT_ACCEPT, WAIT_DONE, GAP, FINISH.
- IDLE:
  - On `go`: `entry_idx`←0, `writes_done`←0, `done`←0, `error`←0, `busy`←1, then go to FETCH.
  - `go` is accepted from IDLE only. FINISH returns to IDLE, so a re-run is allowed; `go` while `busy` is ignored.
- FETCH: latch `entry_addr`/`entry_data` into `i2c_address`/`i2c_data`; latch `last` = `entry_last` OR (`entry_idx`==NUM_REGS-1); go to ISSUE.
- ISSUE: wait for `i2c_ready_n`==0. Once it is low, pulse `i2c_start_write` for exactly one cycle and go to WAIT_ACCEPT.
- WAIT_ACCEPT: wait for `i2c_ready_n`==1, then go to WAIT_DONE.
- WAIT_DONE: wait for `i2c_ready_n`==0. Then `writes_done`++ and:
  - if `last`, go to FINISH;
  - otherwise `entry_idx`++ and go to GAP.
- GAP:
  - Count GAP_CYCLES cycles, then go to FETCH.
  - With GAP_CYCLES==0, go to FETCH directly from WAIT_DONE.
- FINISH: `busy`←0, `done`←1, go to IDLE.
- Counters: gap counter width $clog2(GAP_CYCLES+1); `entry_idx` never wraps (bounded by the forced last at NUM_REGS-1).
- A NACKed transfer can leave `i2c_ready_n` high indefinitely. Without the watchdog the block then waits forever; a `nReset` is required to recover.

## Timing
- Reset values: all outputs 0, state IDLE. `nReset` asserted mid-operation drops `i2c_start_write` and `busy` immediately, asynchronously.
- From `go` sampled high:
  - FETCH on the next edge.
  - `i2c_start_write` high 2 cycles after `go` if `i2c_ready_n` is already low.
- `i2c_address`/`i2c_data` are valid one cycle before `i2c_start_write` and held until the next FETCH.
- Per-write overhead excluding the I2C transfer: 4 cycles plus GAP_CYCLES.
- `done` rises one cycle after the final `i2c_ready_n` falling sample. `done` and `error` are never high together.

## Configuration
- `LMK_INIT_TIMEOUT_EN` defined:
  - A watchdog of width $clog2(TIMEOUT_CYCLES+1) runs in ISSUE, WAIT_ACCEPT and WAIT_DONE, and restarts on every state change.
  - When it reaches TIMEOUT_CYCLES: `error`←1, `busy`←0, return to IDLE. `writes_done` keeps the count reached.
- Not defined: no watchdog logic; `error` is tied to 0.

## Test plan
- 3-entry table (last at idx 2), GAP_CYCLES=4, model asserts `ready_n` 1 cycle after request for 50 cycles -> three `i2c_start_write` pulses with matching addr/data, `writes_done`=3, `done`=1, `busy`=0.
- `entry_last` never set, NUM_REGS=16 -> exactly 16 writes, `entry_idx` stops at 15, `done`=1.
- `i2c_ready_n` held high at `go` for 20 cycles -> no `i2c_start_write` until it falls, then a single pulse.
- `go` pulsed during WAIT_DONE and GAP -> ignored, no extra writes; `go` after `done` -> rerun from idx 0, `done` cleared.
- With `LMK_INIT_TIMEOUT_EN`, TIMEOUT_CYCLES=100, `ready_n` stuck high on write 2 -> `error`=1 after 100 cycles in WAIT_DONE, `writes_done`=1, `done`=0.
- `nReset` low during WAIT_ACCEPT -> all outputs 0 asynchronously; a following `go` restarts cleanly at idx 0.
